// File: rtl/psg_pkg.sv
// psg_pkg: shared PSG channel defaults and mixer width helpers
package psg_pkg;
   localparam int DEFAULT_CHANNELS = 4;
   localparam int DEFAULT_VOLUME_BITS = 15;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic int sum_bits(input int volume_bits, input int channels);
      return volume_bits + clog2(channels);
   endfunction
endpackage

// File: rtl/pwm_modulator.sv
// pwm_modulator: free-running PWM counter, duty loaded once per period on wrap
module pwm_modulator
   import psg_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PWM_BITS-1:0] quant,
   output logic                wrap,
   output logic                pwm_out,
   output logic                strobe
);
   logic [PWM_BITS-1:0] cnt_d, cnt_q, duty_d, duty_q;
   logic pwm_d, pwm_q, strobe_d, strobe_q;
   assign wrap = &cnt_q;
   always_comb begin
      cnt_d = cnt_q + 1'b1;
      duty_d = wrap ? quant : duty_q;
      pwm_d = cnt_q < duty_q;
      strobe_d = wrap;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         duty_q <= '0;
         pwm_q <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         duty_q <= duty_d;
         pwm_q <= pwm_d;
         strobe_q <= strobe_d;
      end
   end
   assign pwm_out = pwm_q;
   assign strobe = strobe_q;
endmodule

// File: rtl/psg_mixer_pwm.sv
// psg_mixer_pwm: sums channel volumes into a PWM pin and sample tap; PSG_MIXER_ERROR_FEEDBACK_EN adds noise shaping
module psg_mixer_pwm
   import psg_pkg::*;
#(
   parameter int CHANNELS = DEFAULT_CHANNELS,
   parameter int VOLUME_BITS = DEFAULT_VOLUME_BITS,
   parameter int PWM_BITS = 8,
   localparam int SUM_BITS = sum_bits(VOLUME_BITS, CHANNELS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [CHANNELS*VOLUME_BITS-1:0] volumes,
   output logic                            pwm_out,
   output logic [SUM_BITS-1:0]             sample,
   output logic                            sample_strobe
);
   localparam int SHIFT = SUM_BITS - PWM_BITS;
   logic [SUM_BITS-1:0] sum, sample_d, sample_q;
   logic [PWM_BITS-1:0] quant;
   logic wrap;
   always_comb begin
      sum = '0;
      for (int i = 0; i < CHANNELS; i++) sum = sum + SUM_BITS'(volumes[i*VOLUME_BITS +: VOLUME_BITS]);
      sample_d = wrap ? sum : sample_q;
   end
   always_ff @(posedge clk) begin
      if (reset) sample_q <= '0;
      else sample_q <= sample_d;
   end
`ifdef PSG_MIXER_ERROR_FEEDBACK_EN
   generate
      if (SHIFT > 0) begin : g_fb
         logic [SHIFT-1:0] residue_d, residue_q;
         logic [SUM_BITS:0] total;
         logic [PWM_BITS:0] quant_raw;
         // residue is dropped on saturation so clipping never accumulates
         always_comb begin
            total = {1'b0, sum} + (SUM_BITS+1)'(residue_q);
            quant_raw = total[SUM_BITS:SHIFT];
            quant = quant_raw[PWM_BITS] ? '1 : quant_raw[PWM_BITS-1:0];
            residue_d = wrap ? (quant_raw[PWM_BITS] ? '0 : total[SHIFT-1:0]) : residue_q;
         end
         always_ff @(posedge clk) begin
            if (reset) residue_q <= '0;
            else residue_q <= residue_d;
         end
      end else begin : g_trunc
         assign quant = sum[PWM_BITS-1:0];
      end
   endgenerate
`else
   assign quant = sum[SUM_BITS-1 -: PWM_BITS];
`endif
   pwm_modulator #(.PWM_BITS(PWM_BITS)) u_pwm (
      .clk(clk),
      .reset(reset),
      .quant(quant),
      .wrap(wrap),
      .pwm_out(pwm_out),
      .strobe(sample_strobe)
   );
   assign sample = sample_q;
endmodule

// File: tb/tb_psg_mixer_pwm.sv
// tb_psg_mixer_pwm: randomized bench against a cycle-index reference model of the mixer
module tb_psg_mixer_pwm;
   localparam int PERIOD = 256;
   logic clk = 1'b0, reset = 1'b1;
   logic [14:0] vols [4];
   logic [59:0] volumes;
   logic pwm_out, sample_strobe;
   logic [16:0] sample;
   int vecs = 0, errs = 0, cyc = 0;
   int load_duty, win_duty, res, hi_cnt, exp_sample;
   logic exp_pwm, exp_strobe, win_done;
   assign volumes = {vols[3], vols[2], vols[1], vols[0]};
   psg_mixer_pwm dut (
      .clk(clk),
      .reset(reset),
      .volumes(volumes),
      .pwm_out(pwm_out),
      .sample(sample),
      .sample_strobe(sample_strobe)
   );
   always #5 clk = ~clk;
   function automatic int quantize(input int s);
      int t, q;
`ifdef PSG_MIXER_ERROR_FEEDBACK_EN
      t = s + res;
      q = t / 512;
      if (q > 255) begin
         q = 255;
         res = 0;
      end else res = t % 512;
`else
      t = s;
      q = t / 512;
`endif
      return q;
   endfunction
   task automatic set_vols(input int a, input int b, input int c, input int d);
      vols[0] = 15'(a);
      vols[1] = 15'(b);
      vols[2] = 15'(c);
      vols[3] = 15'(d);
   endtask
   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      cyc = 0;
      load_duty = 0;
      win_duty = 0;
      res = 0;
      hi_cnt = 0;
      exp_sample = 0;
      exp_pwm = 1'b0;
      exp_strobe = 1'b0;
      win_done = 1'b0;
   endtask
   // cycle c>=1 shows the compare made in cycle c-1; a window starts one cycle after each load
   task automatic tick();
      logic wrap_now;
      int s, q;
      s = 0;
      q = 0;
      wrap_now = (cyc % PERIOD) == PERIOD - 1;
      if (wrap_now) begin
         for (int i = 0; i < 4; i++) s += int'(vols[i]);
         q = quantize(s);
      end
      @(posedge clk);
      #1;
      cyc++;
      exp_strobe = wrap_now;
      if (wrap_now) begin
         exp_sample = s;
         load_duty = q;
      end
      if ((cyc - 1) % PERIOD == 0) begin
         win_duty = load_duty;
         hi_cnt = 0;
      end
      exp_pwm = ((cyc - 1) % PERIOD) < win_duty;
      hi_cnt += int'(pwm_out);
      win_done = (cyc % PERIOD) == 0;
   endtask
   task automatic test_reset();
      set_vols($urandom_range(0, 32767), $urandom_range(0, 32767), $urandom_range(0, 32767), $urandom_range(0, 32767));
      apply_reset();
      vecs += 3;
      if (pwm_out !== 1'b0) begin errs++; $display("FAIL reset_pwm got %b exp 0", pwm_out); end
      if (sample_strobe !== 1'b0) begin errs++; $display("FAIL reset_strobe got %b exp 0", sample_strobe); end
      if (sample !== 17'd0) begin errs++; $display("FAIL reset_sample got %0d exp 0", sample); end
   endtask
   task automatic test_zero();
      set_vols(0, 0, 0, 0);
      apply_reset();
      repeat (4 * PERIOD) begin
         tick();
         vecs += 3;
         if (pwm_out !== 1'b0) begin errs++; $display("FAIL zero_pwm cyc=%0d got %b exp 0", cyc, pwm_out); end
         if (sample_strobe !== (cyc % PERIOD == 0)) begin errs++; $display("FAIL zero_strobe cyc=%0d got %b exp %b", cyc, sample_strobe, cyc % PERIOD == 0); end
         if (sample !== 17'd0) begin errs++; $display("FAIL zero_sample cyc=%0d got %0d exp 0", cyc, sample); end
      end
   endtask
   task automatic test_full();
      set_vols(32767, 32767, 32767, 32767);
      apply_reset();
      repeat (4 * PERIOD) begin
         tick();
         vecs += 3;
         if (pwm_out !== exp_pwm) begin errs++; $display("FAIL full_pwm cyc=%0d got %b exp %b", cyc, pwm_out, exp_pwm); end
         if (sample_strobe !== exp_strobe) begin errs++; $display("FAIL full_strobe cyc=%0d got %b exp %b", cyc, sample_strobe, exp_strobe); end
         if (sample !== 17'(exp_sample)) begin errs++; $display("FAIL full_sample cyc=%0d got %0d exp %0d", cyc, sample, exp_sample); end
         if (win_done && cyc >= 2 * PERIOD) begin
            vecs += 2;
            if (hi_cnt !== 255) begin errs++; $display("FAIL full_high cyc=%0d got %0d exp 255", cyc, hi_cnt); end
            if (sample !== 17'd131068) begin errs++; $display("FAIL full_sum cyc=%0d got %0d exp 131068", cyc, sample); end
         end
      end
   endtask
   task automatic test_midchange();
      set_vols(32767, 0, 0, 0);
      apply_reset();
      repeat (3 * PERIOD) begin
         if (cyc == PERIOD + 150) set_vols(0, 0, 0, 0);
         tick();
         vecs += 3;
         if (pwm_out !== exp_pwm) begin errs++; $display("FAIL mid_pwm cyc=%0d got %b exp %b", cyc, pwm_out, exp_pwm); end
         if (sample_strobe !== exp_strobe) begin errs++; $display("FAIL mid_strobe cyc=%0d got %b exp %b", cyc, sample_strobe, exp_strobe); end
         if (sample !== 17'(exp_sample)) begin errs++; $display("FAIL mid_sample cyc=%0d got %0d exp %0d", cyc, sample, exp_sample); end
         if (win_done && cyc >= 2 * PERIOD) begin
            vecs++;
            if (hi_cnt !== (cyc == 2 * PERIOD ? 63 : 0)) begin errs++; $display("FAIL mid_high cyc=%0d got %0d exp %0d", cyc, hi_cnt, cyc == 2 * PERIOD ? 63 : 0); end
         end
      end
   endtask
   task automatic test_reset_mid();
      int first;
      set_vols(32767, 0, 0, 0);
      apply_reset();
      while (cyc < PERIOD + 100) tick();
      reset = 1'b1;
      @(posedge clk);
      #1;
      vecs += 3;
      if (pwm_out !== 1'b0) begin errs++; $display("FAIL rmid_pwm got %b exp 0", pwm_out); end
      if (sample_strobe !== 1'b0) begin errs++; $display("FAIL rmid_strobe got %b exp 0", sample_strobe); end
      if (sample !== 17'd0) begin errs++; $display("FAIL rmid_sample got %0d exp 0", sample); end
      reset = 1'b0;
      cyc = 0;
      load_duty = 0;
      win_duty = 0;
      res = 0;
      exp_sample = 0;
      first = 0;
      repeat (2 * PERIOD) begin
         tick();
         if (sample_strobe === 1'b1 && first == 0) first = cyc;
         vecs += 2;
         if (pwm_out !== exp_pwm) begin errs++; $display("FAIL rmid_pwm cyc=%0d got %b exp %b", cyc, pwm_out, exp_pwm); end
         if (sample !== 17'(exp_sample)) begin errs++; $display("FAIL rmid_sample cyc=%0d got %0d exp %0d", cyc, sample, exp_sample); end
      end
      vecs++;
      if (first !== PERIOD) begin errs++; $display("FAIL rmid_first_strobe got %0d exp %0d", first, PERIOD); end
   endtask
   task automatic test_random();
      set_vols($urandom_range(0, 32767), $urandom_range(0, 32767), $urandom_range(0, 32767), $urandom_range(0, 32767));
      apply_reset();
      repeat (12 * PERIOD) begin
         if ($urandom_range(0, 63) == 0) vols[$urandom_range(0, 3)] = 15'($urandom_range(0, 32767));
         if ($urandom_range(0, 1023) == 0) set_vols(32767, 32767, 32767, $urandom_range(0, 32767));
         tick();
         vecs += 3;
         if (pwm_out !== exp_pwm) begin errs++; $display("FAIL rand_pwm cyc=%0d got %b exp %b", cyc, pwm_out, exp_pwm); end
         if (sample_strobe !== exp_strobe) begin errs++; $display("FAIL rand_strobe cyc=%0d got %b exp %b", cyc, sample_strobe, exp_strobe); end
         if (sample !== 17'(exp_sample)) begin errs++; $display("FAIL rand_sample cyc=%0d got %0d exp %0d", cyc, sample, exp_sample); end
      end
   endtask
   task automatic test_feedback();
      int p, want;
      set_vols(256, 0, 0, 0);
      apply_reset();
      repeat (6 * PERIOD) begin
         tick();
         if (win_done && cyc >= 2 * PERIOD) begin
            p = cyc / PERIOD - 1;
`ifdef PSG_MIXER_ERROR_FEEDBACK_EN
            want = (p % 2 == 0) ? 1 : 0;
`else
            want = 0;
`endif
            vecs += 2;
            if (hi_cnt !== want) begin errs++; $display("FAIL fb_high period=%0d got %0d exp %0d", p, hi_cnt, want); end
            if (sample !== 17'd256) begin errs++; $display("FAIL fb_sample period=%0d got %0d exp 256", p, sample); end
         end
      end
   endtask
   initial begin
      set_vols(0, 0, 0, 0);
      test_reset();
      test_zero();
      test_full();
      test_midchange();
      test_reset_mid();
      test_random();
      test_feedback();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/psg_mixer_pwm.md
Name: psg_mixer_pwm

Overview:
- Downstream of the four per-channel attenuation stages (3 tone + 1 noise) in the SN76489 PSG.
- Sums the attenuated channel volumes into one unsigned sample.
- Quantizes the sum to PWM resolution and drives a single-bit PWM audio pin. Also exports the full-width sample for the digital audio tap.
- Samples are taken once per PWM period, so each period carries a stable duty cycle.

Parameters:
- CHANNELS, 4, number of attenuated channel inputs.
- VOLUME_BITS, 15, width of each channel volume (matches the attenuation output width).
- PWM_BITS, 8, PWM counter width; period = 2^PWM_BITS clocks; must be <= SUM_BITS.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- volumes  input  CHANNELS*VOLUME_BITS  packed channel volumes; channel i at [i*VOLUME_BITS +: VOLUME_BITS].
- pwm_out  output  1  registered PWM audio bit.
- sample  output  SUM_BITS  registered full-width mixed sum, SUM_BITS = VOLUME_BITS + clog2(CHANNELS).
- sample_strobe  output  1  one-cycle pulse when sample/duty update.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (reset). Reset wins over every other event in the same cycle.
- Reset values: counter = 0, duty = 0, pwm_out = 0, sample = 0, sample_strobe = 0, residue = 0.
- Mixer: sum = unsigned sum of all channels, zero-extended to SUM_BITS. Overflow is impossible by construction.
- SHIFT = SUM_BITS - PWM_BITS. quant = sum >> SHIFT, i.e. plain truncation.
- Counter: PWM_BITS wide, increments every clk. It wraps from 2^PWM_BITS-1 to 0.
- Wrap cycle (counter == all-ones), at the next edge:
  - duty <= quant of the volumes present in this cycle.
  - sample <= sum.
  - sample_strobe <= 1.
- sample_strobe is 0 in every other cycle.
- Volumes are sampled only on the wrap cycle. Changes mid-period are ignored until the next wrap.
- pwm_out is registered: pwm_out <= (counter < duty). This gives one cycle of latency from the counter/duty state.
- High cycles per period equal duty exactly, from 0 to 2^PWM_BITS-1.
  - duty = 0: pwm_out is never high.
  - duty = max: pwm_out is low for 1 cycle per period.
- After reset, the first 2^PWM_BITS cycles output low (duty = 0). The first duty load occurs at the edge after cycle 2^PWM_BITS-1.
- Reset mid-period: counter restarts at 0 and duty clears. The in-flight period is abandoned with no partial strobe.
- No handshake: the upstream attenuators are combinational and always valid.

Optional Feature:
- Macro: PSG_MIXER_ERROR_FEEDBACK_EN.
- With the macro:
  - First-order noise shaping. A SHIFT-bit residue register holds the truncated low bits.
  - On wrap: total = sum + residue (SUM_BITS+1 bits); quant = total >> SHIFT, saturated to 2^PWM_BITS-1.
  - residue <= total[SHIFT-1:0], or 0 if saturation occurred.
  - Reset clears residue.
  - If SHIFT == 0, no residue logic is generated.
- Without the macro: plain truncation, no residue register. This is the default.

Decomposition:
- Shared package psg_pkg holds:
  - the clog2 helper function;
  - the SUM_BITS derivation;
  - default VOLUME_BITS = 15 and CHANNELS = 4, shared with the attenuation and tone blocks.
- One natural sub-module: pwm_modulator.
  - Contains the counter, duty register, wrap detect, compare and pwm_out register.
  - Parameterized by PWM_BITS; takes quant in and emits strobe.
- The mixer adder and the error-feedback logic stay in psg_mixer_pwm.

Test Plan (defaults: SUM_BITS=17, SHIFT=9, period 256):
- Reset, all volumes 0 for 4 periods -> pwm_out constantly 0; sample_strobe pulses every 256 cycles; sample = 0.
- All channels 32767 -> sum 131068, duty 255; after the first load, pwm_out is high 255 of every 256 cycles and low exactly one cycle per period; sample = 131068.
- Channel 0 = 32767, others 0 -> duty 63; exactly 63 high cycles per period, starting one cycle after counter = 0.
- Change channel 0 from 32767 to 0 in the middle of a period -> current period keeps 63 high cycles; next period duty = 0; sample updates only with the strobe.
- Assert reset at counter = 100 while duty = 63 -> next cycle counter = 0 and pwm_out = 0; the next strobe arrives 256 cycles after reset release.
- With PSG_MIXER_ERROR_FEEDBACK_EN, constant sum = 256 -> duty alternates 0, 1, 0, 1 over successive periods. Without the macro -> duty stays 0.
